btn_mode_ctrl: RTL and testbench

- Front-end controller that turns three raw push-buttons into the classified events consumed by the clock/alarm/timer/stopwatch mode blocks: b0short, b0long, b1short, b1long, plus a b0 held level.
- Owns the 2-bit mode register, advanced by the third button.
- Consumers update on a slow strobe, so events are latched until the consumer's sample tick and cannot be missed.
- Sits between the board buttons and all mode blocks.

---
 rtl/btn_mode_ctrl_pkg.sv | 26 ++
 rtl/btn_classifier.sv | 99 +++++++++
 rtl/btn_mode_ctrl.sv | 86 ++++++++
 tb/tb_btn_mode_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/btn_mode_ctrl_pkg.sv
// Shared definitions for the button front-end: mode encodings, classifier
// state type and button index assignments.
package btn_mode_ctrl_pkg;

    localparam logic [1:0] MODE_CLOCK     = 2'b00;
    localparam logic [1:0] MODE_ALARM     = 2'b01;
    localparam logic [1:0] MODE_TIMER     = 2'b10;
    localparam logic [1:0] MODE_STOPWATCH = 2'b11;

    localparam int NUM_BTN  = 3;
    localparam int BTN_B0   = 0;
    localparam int BTN_B1   = 1;
    localparam int BTN_MODE = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        LONG    = 2'b10
    } cls_state_t;

    // Modes cycle clock -> alarm -> timer -> stopwatch -> clock.
    function automatic logic [1:0] mode_advance(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/btn_classifier.sv
// One push-button: 2-flop synchronizer, debouncer and short/long press
// classifier with one-cycle event pulses and a long-press hold level.
module btn_classifier
    import btn_mode_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic short_evt,
    output logic long_evt,
    output logic hold
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    cls_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             short_evt_reg;
    logic             long_evt_reg;
    logic             hold_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            deb_reg     <= 1'b0;
            deb_cnt_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            // The level must disagree for DEB_CYCLES consecutive cycles to flip.
            if (sync2_reg == deb_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                deb_reg     <= ~deb_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            short_evt_reg <= 1'b0;
            long_evt_reg  <= 1'b0;
            hold_reg      <= 1'b0;
        end else begin
            short_evt_reg <= 1'b0;
            long_evt_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (deb_reg) begin
                        state_reg <= PRESSED;
                        cnt_reg   <= '0;
                    end
                end
                PRESSED: begin
                    // A release on the threshold cycle still counts as short.
                    if (!deb_reg) begin
                        short_evt_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else if (cnt_reg == CNT_W'(LONG_CYCLES - 1)) begin
                        long_evt_reg <= 1'b1;
                        hold_reg     <= 1'b1;
                        state_reg    <= LONG;
                    end else if (cnt_reg != CNT_W'(LONG_CYCLES)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LONG: begin
                    if (!deb_reg) begin
                        hold_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    hold_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign short_evt = short_evt_reg;
    assign long_evt  = long_evt_reg;
    assign hold      = hold_reg;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Button front-end: three classifiers, the mode register and the
// tick-latched event flags handed to the slow mode blocks.
module btn_mode_ctrl
    import btn_mode_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    input  logic       tick,
    output logic [1:0] mode,
    output logic       b0short,
    output logic       b0long,
    output logic       b1short,
    output logic       b1long,
    output logic       b0hold
);

    logic [NUM_BTN-1:0] short_evt;
    logic [NUM_BTN-1:0] long_evt;
    logic [NUM_BTN-1:0] hold;
    logic               unused_hold;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_cls
            btn_classifier #(
                .DEB_CYCLES (DEB_CYCLES),
                .LONG_CYCLES(LONG_CYCLES)
            ) u_cls (
                .clk      (clk),
                .rst      (rst),
                .btn_raw  (btn_raw[gi]),
                .short_evt(short_evt[gi]),
                .long_evt (long_evt[gi]),
                .hold     (hold[gi])
            );
        end
    endgenerate

    assign unused_hold = ^hold[NUM_BTN-1:1];

    logic [1:0] mode_reg;
    logic [1:0] mode_next;
    logic [3:0] flag_reg;
    logic [3:0] flag_next;
    logic [3:0] evt_vec;

    // Flag bit order: {b0short, b0long, b1short, b1long}.
    always_comb begin
        evt_vec = {short_evt[BTN_B0], long_evt[BTN_B0], short_evt[BTN_B1], long_evt[BTN_B1]};
        mode_next = mode_reg;
        if (long_evt[BTN_MODE]) begin
            mode_next = MODE_CLOCK;
        end else if (short_evt[BTN_MODE]) begin
            mode_next = mode_advance(mode_reg);
        end
        // A mode switch wipes pending events so the new mode starts clean.
        if (mode_next != mode_reg) begin
            flag_next = '0;
        end else if (tick) begin
            flag_next = evt_vec;
        end else begin
            flag_next = flag_reg | evt_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_reg <= MODE_CLOCK;
            flag_reg <= '0;
        end else begin
            mode_reg <= mode_next;
            flag_reg <= flag_next;
        end
    end

    assign mode    = mode_reg;
    assign b0short = flag_reg[3];
    assign b0long  = flag_reg[2];
    assign b1short = flag_reg[1];
    assign b1long  = flag_reg[0];
    assign b0hold  = hold[BTN_B0];

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: directed scenarios then random button activity,
// every cycle compared against a timestamp-based reference model.
module tb_btn_mode_ctrl;

    localparam int DEB = 4;
    localparam int LNG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic       tick;
    logic [1:0] mode;
    logic       b0short, b0long, b1short, b1long, b0hold;

    always #5 clk = ~clk;

    btn_mode_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .tick   (tick),
        .mode   (mode),
        .b0short(b0short),
        .b0long (b0long),
        .b1short(b1short),
        .b1long (b1long),
        .b0hold (b0hold)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: debounced level flips once the last DEB synchronized
    // samples all disagree with it; press type follows from rise/fall edge times.
    int             n = 0;
    logic           m_s1   [3];
    logic           m_s2   [3];
    logic           m_deb  [3];
    logic [DEB-1:0] m_win  [3];
    int             m_tr   [3];
    int             m_tf   [3];
    logic           m_es   [3];
    logic           m_el   [3];
    logic           m_hold [3];
    logic [1:0]     m_mode;
    logic [3:0]     m_flag;

    task automatic model_step();
        logic [1:0] nm;
        logic [3:0] ev;
        logic       dold;
        n++;
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_deb[b] = 1'b0; m_win[b] = '0;
                m_tr[b] = -1000; m_tf[b] = -1000;
                m_es[b] = 1'b0; m_el[b] = 1'b0; m_hold[b] = 1'b0;
            end
            m_mode = 2'b00;
            m_flag = 4'b0000;
        end else begin
            ev = {m_es[0], m_el[0], m_es[1], m_el[1]};
            if (m_el[2])      nm = 2'b00;
            else if (m_es[2]) nm = 2'((int'(m_mode) + 1) % 4);
            else              nm = m_mode;
            if (nm != m_mode) m_flag = 4'b0000;
            else if (tick)    m_flag = ev;
            else              m_flag = m_flag | ev;
            m_mode = nm;
            for (int b = 0; b < 3; b++) begin
                dold      = m_deb[b];
                m_es[b]   = !dold && (m_tf[b] == n - 1) && (m_tf[b] - m_tr[b] <= LNG);
                m_el[b]   = dold && (n == m_tr[b] + LNG + 1);
                m_hold[b] = dold && (n >= m_tr[b] + LNG + 1);
                m_win[b]  = {m_win[b][DEB-2:0], m_s2[b]};
                if (m_win[b] == {DEB{!dold}}) begin
                    m_deb[b] = !dold;
                    if (!dold) m_tr[b] = n;
                    else       m_tf[b] = n;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = btn_raw[b];
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_val("outputs", {1'b0, mode, b0short, b0long, b1short, b1long, b0hold},
                  {1'b0, m_mode, m_flag, m_hold[0]});
    endtask

    task automatic run_n(input int k);
        for (int i = 0; i < k; i++) run_cycle();
    endtask

    task automatic press(input int b, input int len, input int gap);
        btn_raw[b] = 1'b1;
        run_n(len);
        btn_raw[b] = 1'b0;
        run_n(gap);
    endtask

    int rem [3];

    initial begin
        rst     = 1'b0;
        btn_raw = 3'b111;
        tick    = 1'b0;
        run_n(2);
        check_val("reset_out", 8'({mode, b0short, b0long, b1short, b1long, b0hold}), 8'd0);

        rst = 1'b1;
        run_n(10);
        btn_raw = 3'b000;
        run_n(15);
        check_val("reset_held_mode", 8'(mode), 8'(2'b01));

        for (int i = 0; i < 3; i++) press(2, 10, 15);
        check_val("mode_wrap", 8'(mode), 8'(2'b00));
        for (int i = 0; i < 2; i++) press(2, 10, 15);
        check_val("mode_timer", 8'(mode), 8'(2'b10));
        press(2, 30, 15);
        check_val("mode_long", 8'(mode), 8'(2'b00));

        press(1, 10, 15);
        check_val("b1short_latched", 8'(b1short), 8'd1);
        tick = 1'b1;
        run_cycle();
        tick = 1'b0;
        check_val("b1short_tick_clear", 8'(b1short), 8'd0);

        press(1, 10, 7);
        tick = 1'b1;
        run_cycle();
        tick = 1'b0;
        check_val("evt_with_tick", 8'(b1short), 8'd1);
        run_cycle();

        btn_raw[0] = 1'b1;
        run_n(35);
        check_val("b0long_set", 8'(b0long), 8'd1);
        check_val("b0hold_set", 8'(b0hold), 8'd1);
        btn_raw[0] = 1'b0;
        run_n(15);
        check_val("b0hold_clear", 8'(b0hold), 8'd0);
        check_val("b0short_none", 8'(b0short), 8'd0);

        btn_raw[0] = 1'b1;
        run_n(30);
        press(1, 8, 15);
        tick = 1'b1;
        check_val("combo_hold_short", 8'({b0hold, b1short}), 8'(2'b11));
        run_cycle();
        tick = 1'b0;
        btn_raw[0] = 1'b0;
        run_n(15);

        tick = 1'b1;
        run_cycle();
        tick = 1'b0;
        press(1, 2, 15);
        check_val("glitch_ignored", 8'({b1short, b1long}), 8'd0);
        press(1, 10, 15);
        check_val("b1short_pending", 8'(b1short), 8'd1);
        press(2, 10, 15);
        check_val("mode_clears_flags", 8'(b1short), 8'd0);

        for (int b = 0; b < 3; b++) rem[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                rem[b]--;
                if (rem[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 45));
                end
            end
            tick = ($urandom_range(0, 15) == 0);
            rst  = !($urandom_range(0, 999) == 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
